// File: rtl/i2c_config_seq.sv
// I2C configuration sequencer: streams a table of {register address, data} entries
// to one codec address as write transactions, retrying NACKed entries a bounded number of times.
module i2c_config_seq #(
   parameter int         CLK_DIV     = 120,
   parameter logic [6:0] DEV_ADDR    = 7'h3B,
   parameter int         NUM_ENTRIES = 64,
   parameter int         TBL_AW      = 6,
   parameter int         REG_BYTES   = 2,
   parameter int         DATA_BYTES  = 1,
   parameter int         MAX_RETRY   = 3
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   output logic [TBL_AW-1:0]                     tbl_addr,
   input  logic [8*(REG_BYTES+DATA_BYTES)-1:0]   tbl_data,
   output logic                                  i2c_scl,
   input  logic                                  i2c_sda_i,
   output logic                                  i2c_sda_o,
   output logic                                  i2c_sda_t,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  error,
   output logic [TBL_AW-1:0]                     err_index
);

   localparam int Q       = CLK_DIV / 4;
   localparam int QW      = (Q > 1) ? $clog2(Q) : 1;
   localparam int NB      = 1 + REG_BYTES + DATA_BYTES;
   localparam int BW      = $clog2(NB + 1);
   localparam int FRAME_W = 8 * NB;
   localparam int RW      = $clog2(MAX_RETRY + 2);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
   } state_t;

   state_t               state_q, state_d;
   logic [QW-1:0]        qcnt_q, qcnt_d;
   logic [1:0]           phase_q, phase_d;
   logic [2:0]           bit_q, bit_d;
   logic [BW-1:0]        byte_q, byte_d;
   logic [1:0]           fcnt_q, fcnt_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic [TBL_AW-1:0]    index_q, index_d;
   logic [TBL_AW-1:0]    err_index_q, err_index_d;
   logic                 nack_q, nack_d;
   logic [FRAME_W-1:0]   sh_q, sh_d;

   logic scl_c, sda_t_c, q_end, bit_end;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         qcnt_q      <= '0;
         phase_q     <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         fcnt_q      <= '0;
         retry_q     <= '0;
         index_q     <= '0;
         err_index_q <= '0;
         nack_q      <= 1'b0;
         sh_q        <= '0;
      end else begin
         state_q     <= state_d;
         qcnt_q      <= qcnt_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         fcnt_q      <= fcnt_d;
         retry_q     <= retry_d;
         index_q     <= index_d;
         err_index_q <= err_index_d;
         nack_q      <= nack_d;
         sh_q        <= sh_d;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d     = state_q;
      qcnt_d      = qcnt_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      fcnt_d      = fcnt_q;
      retry_d     = retry_q;
      index_d     = index_q;
      err_index_d = err_index_q;
      nack_d      = nack_q;
      sh_d        = sh_q;
      scl_c       = 1'b1;
      sda_t_c     = 1'b1;
      q_end       = (qcnt_q == QW'(Q - 1));
      bit_end     = q_end && (phase_q == 2'd3);

      // Bus states share one quarter-period timebase; phase counts quarters within a bit.
      if (state_q inside {S_START, S_BYTE, S_ACK, S_STOP, S_GAP}) begin
         qcnt_d  = q_end ? '0 : qcnt_q + 1'b1;
         phase_d = q_end ? phase_q + 2'd1 : phase_q;
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               index_d     = '0;
               retry_d     = '0;
               err_index_d = '0;
               fcnt_d      = '0;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            fcnt_d = fcnt_q + 2'd1;
            nack_d = 1'b0;
            if (fcnt_q == 2'd2) begin
               sh_d    = {DEV_ADDR, 1'b0, tbl_data};
               qcnt_d  = '0;
               phase_d = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            sda_t_c = 1'b0;
            if (q_end && phase_q == 2'd1) begin
               phase_d = '0;
               bit_d   = '0;
               byte_d  = '0;
               state_d = S_BYTE;
            end
         end
         S_BYTE: begin
            scl_c   = phase_q[1];
            sda_t_c = sh_q[FRAME_W-1];
            if (bit_end) begin
               sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_ACK;
            end
         end
         S_ACK: begin
            scl_c = phase_q[1];
            if (q_end && phase_q == 2'd2) nack_d = i2c_sda_i;
            if (bit_end) begin
               if (nack_q || byte_q == BW'(NB - 1)) begin
                  state_d = S_STOP;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = S_BYTE;
               end
            end
         end
         S_STOP: begin
            // Pull SDA low under a low SCL first so the rising SDA edge is the only event.
            scl_c   = phase_q[0];
            sda_t_c = 1'b0;
            if (q_end && phase_q == 2'd1) begin
               phase_d = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (bit_end) begin
               fcnt_d = '0;
               if (!nack_q) begin
                  retry_d = '0;
                  if (index_q == TBL_AW'(NUM_ENTRIES - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     index_d = index_q + 1'b1;
                     state_d = S_FETCH;
                  end
               end else if (retry_q == RW'(MAX_RETRY)) begin
                  err_index_d = index_q;
                  state_d     = S_ERR;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tbl_addr  = index_q;
   assign i2c_scl   = scl_c;
   assign i2c_sda_t = sda_t_c;
   assign i2c_sda_o = 1'b0;
   assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
   assign done      = (state_q == S_DONE);
   assign error     = (state_q == S_ERR);
   assign err_index = err_index_q;

endmodule
